// File: rtl/valrdy_fifo_entry.sv
// One FIFO storage slot: a BITWIDTH-wide register that loads only when enabled
// and clears asynchronously on reset.
module valrdy_fifo_entry #(
    parameter int BITWIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [BITWIDTH-1:0] d_i,
    output logic [BITWIDTH-1:0] q_o
);

    logic [BITWIDTH-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/valrdy_fifo.sv
// Val/rdy FIFO built from DEPTH enable-gated entry registers. Ready and valid
// derive only from the registered occupancy count, so SEND_RDY never reaches RECV_RDY.
module valrdy_fifo #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [BITWIDTH-1:0]      RECV_MSG,
    input  logic                     RECV_VAL,
    output logic                     RECV_RDY,
    output logic [BITWIDTH-1:0]      SEND_MSG,
    output logic                     SEND_VAL,
    input  logic                     SEND_RDY,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                enq_fire, deq_fire;
    logic [BITWIDTH-1:0] entry_q [DEPTH];

    assign RECV_RDY = (count_q != FULL_CNT);
    assign SEND_VAL = (count_q != '0);
    assign COUNT    = count_q;
    assign enq_fire = RECV_VAL && RECV_RDY;
    assign deq_fire = SEND_VAL && SEND_RDY;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            valrdy_fifo_entry #(
                .BITWIDTH(BITWIDTH)
            ) u_entry (
                .clk_i(CLK),
                .rst_i(RESET),
                .en_i (enq_fire && (wr_ptr_q == PTR_W'(gi))),
                .d_i  (RECV_MSG),
                .q_o  (entry_q[gi])
            );
        end
    endgenerate

    assign SEND_MSG = entry_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous enqueue and dequeue leave the occupancy unchanged.
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_valrdy_fifo.sv
// Self-checking bench for valrdy_fifo: directed scenarios plus random traffic,
// all checked against a queue-based model of FIFO behaviour.
module tb_valrdy_fifo;

    localparam int BW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] recv_msg = '0;
    logic          recv_val = 1'b0;
    logic          recv_rdy;
    logic [BW-1:0] send_msg;
    logic          send_val;
    logic          send_rdy = 1'b0;
    logic [2:0]    count;

    int errors = 0;
    int checks = 0;
    logic [BW-1:0] model_q [$];

    valrdy_fifo #(.BITWIDTH(BW), .DEPTH(DEPTH)) dut (
        .CLK     (clk),
        .RESET   (rst),
        .RECV_MSG(recv_msg),
        .RECV_VAL(recv_val),
        .RECV_RDY(recv_rdy),
        .SEND_MSG(send_msg),
        .SEND_VAL(send_val),
        .SEND_RDY(send_rdy),
        .COUNT   (count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [BW-1:0] m, input logic r);
        recv_val = v;
        recv_msg = m;
        send_rdy = r;
    endtask

    // Advance one rising edge; the model applies FIFO rules to the inputs seen at that edge.
    task automatic edge_step();
        bit enq, deq;
        enq = recv_val && (model_q.size() < DEPTH);
        deq = send_rdy && (model_q.size() > 0);
        @(posedge clk);
        if (!rst) begin
            if (deq) void'(model_q.pop_front());
            if (enq) model_q.push_back(recv_msg);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        repeat (2) edge_step();
        model_q.delete();
        checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL reset_recv_rdy got=%b exp=1", recv_rdy); end
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL reset_send_val got=%b exp=0", send_val); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (send_msg !== '0) begin errors++; $display("FAIL reset_send_msg got=%h exp=0", send_msg); end
        #2 rst = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b0);
        repeat (2) edge_step();
        drive(1'b0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_q.delete();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_reset_count got=%0d exp=0", count); end
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL async_reset_send_val got=%b exp=0", send_val); end
        checks++; if (send_msg !== '0) begin errors++; $display("FAIL async_reset_send_msg got=%h exp=0", send_msg); end
        #1 rst = 1'b0;
        edge_step();
        $display("test_reset done: count=%0d", count);
    endtask

    task automatic test_passthrough();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1);
        edge_step();
        drive(1'b0, '0, 1'b1);
        checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL pass_send_val got=%b exp=1", send_val); end
        checks++; if (send_msg !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pass_send_msg got=%h exp=deadbeef", send_msg); end
        edge_step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL pass_count got=%0d exp=0", count); end
        $display("test_passthrough: count=%0d", count);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, BW'(i), 1'b0);
            edge_step();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (recv_rdy !== 1'b0) begin errors++; $display("FAIL fill_recv_rdy got=%b exp=0", recv_rdy); end
        drive(1'b1, 32'd5, 1'b0);
        edge_step();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_reject_count got=%0d exp=4", count); end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, '0, 1'b1);
            checks++; if (send_msg !== BW'(i)) begin errors++; $display("FAIL drain_msg got=%0d exp=%0d", send_msg, i); end
            edge_step();
            checks++; if (count !== 3'(4 - i)) begin errors++; $display("FAIL drain_count got=%0d exp=%0d", count, 4 - i); end
        end
        $display("test_fill: drained, count=%0d", count);
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + BW'(i), 1'b0);
            edge_step();
        end
        drive(1'b1, 32'hBAD, 1'b1);
        edge_step();
        drive(1'b0, '0, 1'b0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_simul_count got=%0d exp=3", count); end
        checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL full_simul_recv_rdy got=%b exp=1", recv_rdy); end
        checks++; if (send_msg !== 32'h101) begin errors++; $display("FAIL full_simul_head got=%h exp=101", send_msg); end
        drive(1'b0, '0, 1'b1);
        repeat (3) edge_step();
        $display("test_full_simul: count=%0d", count);
    endtask

    task automatic test_stream();
        drive(1'b1, 32'd0, 1'b0);
        edge_step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, BW'(i + 1), 1'b1);
            checks++; if (send_msg !== BW'(i)) begin errors++; $display("FAIL stream_msg got=%0d exp=%0d", send_msg, i); end
            edge_step();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count got=%0d exp=1", count); end
        end
        drive(1'b0, '0, 1'b1);
        edge_step();
        $display("test_stream: count=%0d", count);
    endtask

    task automatic test_reset_mid();
        for (int i = 7; i <= 9; i++) begin
            drive(1'b1, BW'(i), 1'b0);
            edge_step();
        end
        drive(1'b0, '0, 1'b0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
        #2 rst = 1'b1;
        #1;
        model_q.delete();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", count); end
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL mid_reset_send_val got=%b exp=0", send_val); end
        #1 rst = 1'b0;
        drive(1'b1, 32'd10, 1'b0);
        edge_step();
        drive(1'b0, '0, 1'b1);
        checks++; if (send_msg !== 32'd10) begin errors++; $display("FAIL mid_next_msg got=%0d exp=10", send_msg); end
        edge_step();
        $display("test_reset_mid: count=%0d", count);
    endtask

    task automatic test_random();
        int start_err;
        start_err = errors;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
            #1;
            checks++; if (count !== 3'(model_q.size())) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", count, model_q.size()); end
            checks++; if (recv_rdy !== (model_q.size() != DEPTH)) begin errors++; $display("FAIL rand_recv_rdy got=%b size=%0d", recv_rdy, model_q.size()); end
            checks++; if (send_val !== (model_q.size() != 0)) begin errors++; $display("FAIL rand_send_val got=%b size=%0d", send_val, model_q.size()); end
            if (model_q.size() != 0) begin
                checks++; if (send_msg !== model_q[0]) begin errors++; $display("FAIL rand_send_msg got=%h exp=%h", send_msg, model_q[0]); end
            end
            edge_step();
        end
        $display("test_random: 400 cycles, new errors=%0d", errors - start_err);
    endtask

    initial begin
        #1;
        test_reset();
        test_passthrough();
        test_fill();
        test_full_simul();
        test_stream();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
